// File: rtl/pwm_pkg.sv
// Shared encodings and helpers for the multichannel PWM block.
package pwm_pkg;

    typedef enum logic {
        PWM_EDGE   = 1'b0,
        PWM_CENTER = 1'b1
    } pwm_mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } pwm_dir_e;

    // Full-scale terminal count, giving the legacy 2^width-cycle period.
    function automatic int unsigned pwm_default_period(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

    // Channel-select width, never narrower than one bit.
    function automatic int pwm_sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: shadow/active duty pair, commit with write bypass, compare, output flop.
module pwm_channel #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             commit,
    input  logic             wr,
    input  logic [WIDTH-1:0] cnt,
    input  logic [WIDTH-1:0] wr_duty,
    output logic             pwm
);

    logic [WIDTH-1:0] duty_sh;
    logic [WIDTH-1:0] duty_act;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_sh  <= '0;
            duty_act <= '0;
            pwm      <= 1'b0;
        end else begin
            if (wr)
                duty_sh <= wr_duty;
            // A write landing on a commit edge goes straight to the active copy.
            if (commit)
                duty_act <= wr ? wr_duty : duty_sh;
            pwm <= en && (cnt < duty_act);
        end
    end

endmodule

// File: rtl/pwm_multichannel.sv
// Shared edge/center-aligned counter with shadowed period/mode driving NUM_CH PWM channels.
module pwm_multichannel
    import pwm_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         mode_in,
    input  logic [WIDTH-1:0]             period_in,
    input  logic                         wr_en,
    input  logic [pwm_sel_w(NUM_CH)-1:0] wr_ch,
    input  logic [WIDTH-1:0]             wr_duty,
    output logic [NUM_CH-1:0]            pwm_out,
    output logic                         period_end
);

    localparam logic [WIDTH-1:0] PER_RST = WIDTH'(pwm_default_period(WIDTH));

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_nxt;
    logic [WIDTH-1:0] per_act;
    pwm_dir_e         dir;
    pwm_dir_e         dir_nxt;
    pwm_mode_e        mode_act;
    logic             center;
    logic             terminal;
    logic             commit;
    logic [NUM_CH-1:0] sel;

    // Center counting needs at least two steps up; shorter periods fall back to edge.
    always_comb begin
        center   = (mode_act == PWM_CENTER) && (per_act >= WIDTH'(2));
        terminal = center ? ((dir == DIR_DOWN) && (cnt == WIDTH'(1))) : (cnt == per_act);
        commit   = !en || terminal;
        cnt_nxt  = cnt + WIDTH'(1);
        dir_nxt  = dir;
        if (!en || terminal) begin
            cnt_nxt = '0;
            dir_nxt = DIR_UP;
        end else if (center && (dir == DIR_UP) && (cnt == per_act)) begin
            cnt_nxt = cnt - WIDTH'(1);
            dir_nxt = DIR_DOWN;
        end else if (dir == DIR_DOWN) begin
            cnt_nxt = cnt - WIDTH'(1);
        end
    end

    assign period_end = en && terminal;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            dir      <= DIR_UP;
            per_act  <= PER_RST;
            mode_act <= PWM_EDGE;
        end else begin
            cnt <= cnt_nxt;
            dir <= dir_nxt;
            if (commit) begin
                per_act  <= period_in;
                mode_act <= pwm_mode_e'(mode_in);
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        // Out-of-range channel numbers match no instance and are dropped.
        assign sel[i] = wr_en && (int'(wr_ch) == i);

        pwm_channel #(
            .WIDTH(WIDTH)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .en     (en),
            .commit (commit),
            .wr     (sel[i]),
            .cnt    (cnt),
            .wr_duty(wr_duty),
            .pwm    (pwm_out[i])
        );
    end

endmodule

// File: tb/tb_pwm_multichannel.sv
// Directed bench for pwm_multichannel: a 4-channel and a 3-channel instance share stimulus.
module tb_pwm_multichannel;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       mode_in;
    logic [7:0] period_in;
    logic       wr_en;
    logic [1:0] wr_ch;
    logic [7:0] wr_duty;
    logic [3:0] pwm4;
    logic       pe4;
    logic [2:0] pwm3;
    logic       pe3;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    pwm_multichannel #(.NUM_CH(4), .WIDTH(8)) u_dut (
        .clk(clk), .rst(rst), .en(en), .mode_in(mode_in), .period_in(period_in),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_duty(wr_duty),
        .pwm_out(pwm4), .period_end(pe4)
    );

    pwm_multichannel #(.NUM_CH(3), .WIDTH(8)) u_dut3 (
        .clk(clk), .rst(rst), .en(en), .mode_in(mode_in), .period_in(period_in),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_duty(wr_duty),
        .pwm_out(pwm3), .period_end(pe3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] ch, input logic [7:0] d);
        wr_en = 1'b1; wr_ch = ch; wr_duty = d;
        tick();
        wr_en = 1'b0;
    endtask

    // Cycles until the next period_end, bounded; also ORs every pwm sample seen.
    task automatic wait_pe(input int max, output int n, output logic [3:0] seen);
        n = 0;
        seen = '0;
        do begin
            tick();
            n++;
            seen |= pwm4;
        end while (!pe4 && n < max);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         n;
        int         c;
        int         hi0;
        int         hi1a;
        int         hi1b;
        logic [3:0] seen;
        logic [3:0] exp;
        int         seq [8] = '{0, 1, 2, 3, 4, 3, 2, 1};

        rst = 1'b1; en = 1'b0; mode_in = 1'b0; period_in = 8'd255;
        wr_en = 1'b0; wr_ch = 2'd0; wr_duty = 8'd0;
        tick(); tick();
        chk("rst_pwm", 32'(pwm4), 0);
        chk("rst_pe", 32'(pe4), 0);
        chk("rst_pwm3", 32'(pwm3), 0);

        // Reset defaults: free-running 256-cycle edge PWM, all low
        en = 1'b1; rst = 1'b0;
        wait_pe(300, n, seen);
        chk("dflt_first_pe", n, 255);
        chk("dflt_low_a", 32'(seen), 0);
        wait_pe(300, n, seen);
        chk("dflt_period", n, 256);
        chk("dflt_low_b", 32'(seen), 0);

        // Edge mode, period 10: ch0=3, ch1=10 (above period), ch2=0
        en = 1'b0; period_in = 8'd9;
        wr(2'd0, 8'd3); wr(2'd1, 8'd10); wr(2'd2, 8'd0);
        en = 1'b1;
        hi0 = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            c = (k - 1) % 10;
            exp = {1'b0, 1'b0, 1'b1, c < 3};
            chk("edge_pwm", 32'(pwm4), 32'(exp));
            chk("edge_pe", 32'(pe4), 32'((k % 10) == 9));
            hi0 += int'(pwm4[0]);
        end
        chk("edge_hi0", hi0, 6);

        // Mid-period duty change on ch1: 8 -> 5 written at cnt=2
        en = 1'b0;
        wr(2'd1, 8'd8);
        en = 1'b1;
        hi1a = 0; hi1b = 0;
        for (int k = 1; k <= 20; k++) begin
            if (k == 3) begin
                wr_en = 1'b1; wr_ch = 2'd1; wr_duty = 8'd5;
            end
            tick();
            wr_en = 1'b0;
            c = (k - 1) % 10;
            exp = {1'b0, 1'b0, c < (((k - 1) < 10) ? 8 : 5), c < 3};
            chk("glitch_pwm", 32'(pwm4), 32'(exp));
            if (k <= 10) hi1a += int'(pwm4[1]);
            else         hi1b += int'(pwm4[1]);
        end
        chk("glitch_hi_old", hi1a, 8);
        chk("glitch_hi_new", hi1b, 5);

        // Center mode, period_in 4: cnt 0,1,2,3,4,3,2,1; ch0 duty 2, ch1 duty 5
        en = 1'b0; mode_in = 1'b1; period_in = 8'd4;
        wr(2'd0, 8'd2);
        en = 1'b1;
        hi0 = 0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            c = seq[(k - 1) % 8];
            exp = {1'b0, 1'b0, 1'b1, c < 2};
            chk("ctr_pwm", 32'(pwm4), 32'(exp));
            chk("ctr_pe", 32'(pe4), 32'((k % 8) == 7));
            hi0 += int'(pwm4[0]);
        end
        chk("ctr_hi0", hi0, 6);

        // Back to edge, period 10; write ch3 in the terminal cycle
        en = 1'b0; mode_in = 1'b0; period_in = 8'd9;
        tick();
        en = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            if (k == 10) begin
                chk("term_pe", 32'(pe4), 1);
                wr_en = 1'b1; wr_ch = 2'd3; wr_duty = 8'd4;
            end
            tick();
            wr_en = 1'b0;
            c = (k - 1) % 10;
            exp = {c < (((k - 1) < 10) ? 0 : 4), 1'b0, c < 5, c < 2};
            chk("term_pwm", 32'(pwm4), 32'(exp));
            chk("nch3_pwm", 32'(pwm3), 32'(exp[2:0]));
        end

        // Async reset mid-period with duty 100
        en = 1'b0; period_in = 8'd255;
        wr(2'd0, 8'd100);
        en = 1'b1;
        repeat (50) tick();
        chk("pre_rst_hi", 32'(pwm4[0]), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_pwm", 32'(pwm4), 0);
        chk("rst_async_pe", 32'(pe4), 0);
        chk("rst_async_pwm3", 32'(pwm3), 0);
        period_in = 8'd9;
        tick(); tick();
        rst = 1'b0;
        wait_pe(300, n, seen);
        chk("post_rst_period", n, 255);
        chk("post_rst_low_a", 32'(seen), 0);
        wait_pe(300, n, seen);
        chk("post_rst_new_per", n, 10);
        chk("post_rst_low_b", 32'(seen), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pwm_multichannel.md
PWM_MULTICHANNEL -- requirements
Module: pwm_multichannel

Interface
REQ-001 Parameter NUM_CH, default 4, number of PWM channels (1..16) SHALL be supported.
REQ-002 Parameter WIDTH, default 8, counter/period/duty width in bits (4..16) SHALL be supported.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 en  input  1  run enable; low holds counter idle.
REQ-006 mode_in  input  1  0 = edge-aligned, 1 = center-aligned; shadowed.
REQ-007 period_in  input  WIDTH  terminal count; shadowed.
REQ-008 wr_en  input  1  duty write strobe, single cycle, no backpressure.
REQ-009 wr_ch  input  max(1,$clog2(NUM_CH))  target channel of the duty write.
REQ-010 wr_duty  input  WIDTH  duty value written to the channel's shadow register.
REQ-011 pwm_out  output  NUM_CH  registered PWM outputs, bit i = channel i.
REQ-012 period_end  output  1  high for one cycle in each terminal cycle.

Function
REQ-013 Counter cnt (WIDTH bits) and direction dir SHALL be shared by all channels.
REQ-014 Edge mode: cnt SHALL count 0..per_act, then wrap to 0; the terminal cycle is cnt==per_act; the period is per_act+1 cycles.
REQ-015 Center mode, per_act>=2: cnt SHALL count up 0..per_act, then down per_act-1..1; the terminal cycle is the down-phase cnt==1; the period is 2*per_act cycles.
REQ-016 Center mode, per_act<=1: behaviour SHALL equal edge mode.
REQ-017 per_act==0: cnt SHALL stay 0 and every cycle SHALL be terminal.
REQ-018 Each channel SHALL hold a shadow duty (duty_sh) and an active duty (duty_act); a write with wr_en=1 SHALL load duty_sh[wr_ch]<=wr_duty on the next edge.
REQ-019 A write with wr_ch>=NUM_CH SHALL be ignored.
REQ-020 In a terminal cycle, duty_act<=duty_sh, per_act<=period_in and mode_act<=mode_in SHALL load on that edge; a write in the same cycle SHALL be bypassed into duty_act (the new value wins).
REQ-021 pwm_out[i] SHALL be assigned <= en && (cnt < duty_act[i]) on each edge, giving one cycle of latency from cnt.
REQ-022 Duty 0 SHALL give constant low; duty > per_act SHALL give constant high (edge mode, and center mode at the peak).
REQ-023 period_end SHALL equal en && terminal, decoded from registered state with no combinational path from any input except en.
REQ-024 While en=0: cnt=0, dir=up, pwm_out=0, period_end=0, and shadow-to-active commit SHALL occur every cycle.
REQ-025 Comparisons SHALL be unsigned, and no intermediate SHALL exceed WIDTH+1 bits.
REQ-026 A mode change SHALL take effect only at a terminal cycle; the counter restarts from 0 counting up.

Reset
REQ-027 On rst: cnt=0, dir=up, all duty_sh and duty_act=0, per_act={WIDTH{1'b1}}, mode_act=edge, pwm_out=0, period_end=0.
REQ-028 Reset during a period SHALL force outputs low immediately; after release, the first period SHALL start at cnt=0.
REQ-029 Reset defaults SHALL reproduce the legacy free-running 2^WIDTH-cycle edge PWM with duty 0.

Structure
REQ-030 Package pwm_pkg SHALL hold the mode encoding (PWM_EDGE, PWM_CENTER), the direction encoding, and the default-period constant function.
REQ-031 Sub-module pwm_channel (duty_sh, duty_act, bypass commit, compare, output flop) SHALL be instantiated NUM_CH times via generate.
REQ-032 The top level SHALL hold only the counter, direction, terminal decode, and the period/mode shadows.

Verification (WIDTH=8, NUM_CH=4)
REQ-033 Reset, en=1, no writes -> all pwm_out=0; period_end every 256 cycles.
REQ-034 Edge mode, period_in=9, ch0 duty 3 / ch1 duty 10 / ch2 duty 0 -> ch0 high 3 of every 10 cycles, ch1 constant high, ch2 constant low, period_end every 10 cycles.
REQ-035 Write ch1 duty 5 at cnt=2 while its old duty is 8 -> 8 high cycles complete, then 5 high cycles from the next period; no glitch.
REQ-036 Center mode, period_in=4, duty 2 -> cnt sequence 0,1,2,3,4,3,2,1 repeats; pwm_out high 3 of 8 cycles, lagging cnt by 1 cycle; period_end at down-phase cnt=1.
REQ-037 Write ch3 in a terminal cycle -> new duty active in the next period; write with wr_ch=3 under NUM_CH=3 -> no channel changes.
REQ-038 rst pulse mid-period with duty 100 -> pwm_out drops in the same cycle; after release, per_act=255 and all outputs low.
